// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : layer_compositor
//  Purpose  : Per-pixel colour compositor. Resolves NUM_LAYERS sprite-hit
//             flags by fixed priority (layer 0 highest) and colours the
//             winner from a writable palette or the texture input. It then
//             selects screen content by game mode, applies a per-frame fade
//             between mode screens, and draws the mouse cursor on top.
//             Two-stage pipeline: pixel inputs at cycle t reach VGA_* at t+2.
//  Ports    : Clk, Reset (sync, active-high)
//             frame_start                 - fade step pulse, once per frame
//             DrawX/DrawY, mouse_x/mouse_y - pixel and cursor coordinates
//             layer_hit, tex_rgb          - sprite hit flags, texture colour
//             start/ingame/gameover_signal - requested screen
//             leftButton, rightButton     - cursor colour select
//             pal_we/pal_addr/pal_data    - palette write port
//             VGA_R/G/B                   - registered output colour
//             fading                      - fade in progress
//  Revision : 1.0  initial release
// ============================================================================
module layer_compositor #(
  parameter int                      NUM_LAYERS  = 24,
  parameter int                      CW          = 8,
  parameter int                      FADE_BITS   = 4,
  parameter int                      CURSOR_HALF = 3,
  parameter logic [NUM_LAYERS-1:0]   LAYER_TEX   = NUM_LAYERS'(3),
  parameter logic [3*CW-1:0]         BG_RGB      = (3*CW)'(24'h808080),
  parameter logic [3*CW-1:0]         START_RGB   = (3*CW)'(24'h6600FF),
  parameter logic [3*CW-1:0]         OVER_RGB    = (3*CW)'(24'h000000),
  localparam int                     AW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_start,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic [NUM_LAYERS-1:0] layer_hit,
  input  logic [3*CW-1:0]       tex_rgb,
  input  logic                  start_signal,
  input  logic                  ingame_signal,
  input  logic                  gameover_signal,
  input  logic [9:0]            mouse_x,
  input  logic [9:0]            mouse_y,
  input  logic                  leftButton,
  input  logic                  rightButton,
  input  logic                  pal_we,
  input  logic [AW-1:0]         pal_addr,
  input  logic [3*CW-1:0]       pal_data,
  output logic [CW-1:0]         VGA_R,
  output logic [CW-1:0]         VGA_G,
  output logic [CW-1:0]         VGA_B,
  output logic                  fading
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FADE_OUT = 2'd1;
  localparam logic [1:0] S_FADE_IN  = 2'd2;

  localparam logic [1:0] M_GAME  = 2'd0;
  localparam logic [1:0] M_START = 2'd1;
  localparam logic [1:0] M_OVER  = 2'd2;

  localparam logic [FADE_BITS:0] c_LMAX = (FADE_BITS+1)'(2**FADE_BITS);
  localparam logic signed [10:0] c_CH   = 11'(CURSOR_HALF);

  // gameover_signal is implied: neither other request set means OVER
  logic w_unused_gameover;
  assign w_unused_gameover = gameover_signal;

  // ---------------- Palette ----------------
  logic [3*CW-1:0] r_pal [NUM_LAYERS];

  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (Reset)
        r_pal[i] <= '1;
      else if (pal_we && pal_addr == AW'(i))
        r_pal[i] <= pal_data;
    end
  end

  // ---------------- Stage A: priority resolve, cursor hit ----------------
  logic            w_any;
  logic [3*CW-1:0] w_col;

  // Scan from lowest priority upward so the lowest set index is assigned last.
  always_comb begin
    w_any = 1'b0;
    w_col = '0;
    for (int i = NUM_LAYERS-1; i >= 0; i--) begin
      if (layer_hit[i]) begin
        w_any = 1'b1;
        w_col = LAYER_TEX[i] ? tex_rgb : r_pal[i];
      end
    end
  end

  // Signed 11-bit differences so a cursor near 0 still hits pixels at 0.
  logic signed [10:0] w_dx, w_dy;
  logic               w_cur_hit;
  logic [3*CW-1:0]    w_cur_col;

  assign w_dx      = $signed({1'b0, DrawX}) - $signed({1'b0, mouse_x});
  assign w_dy      = $signed({1'b0, DrawY}) - $signed({1'b0, mouse_y});
  assign w_cur_hit = (w_dx < c_CH) && (w_dx > -c_CH) && (w_dy < c_CH) && (w_dy > -c_CH);
  assign w_cur_col = leftButton  ? (3*CW)'(24'hFF0000) :
                     rightButton ? (3*CW)'(24'h00FF00) : (3*CW)'(24'hCCCCCC);

  logic            r_any;
  logic [3*CW-1:0] r_col;
  logic            r_cur;
  logic [3*CW-1:0] r_cur_col;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_any     <= 1'b0;
      r_col     <= '0;
      r_cur     <= 1'b0;
      r_cur_col <= '0;
    end else begin
      r_any     <= w_any;
      r_col     <= w_col;
      r_cur     <= w_cur_hit;
      r_cur_col <= w_cur_col;
    end
  end

  // ---------------- Mode / fade FSM ----------------
  logic [1:0]         r_state;
  logic [1:0]         r_shown;
  logic [FADE_BITS:0] r_lvl;
  logic [1:0]         w_req;

  assign w_req  = ingame_signal ? M_GAME : (start_signal ? M_START : M_OVER);
  // Asserted combinationally on the cycle a new request is first seen.
  assign fading = (r_state != S_IDLE) || (w_req != r_shown);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_shown <= M_START;
      r_lvl   <= c_LMAX;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req != r_shown)
            r_state <= S_FADE_OUT;
        end
        S_FADE_OUT: begin
          if (frame_start) begin
            // Screen swaps on the step that reaches black.
            if (r_lvl <= (FADE_BITS+1)'(1)) begin
              r_lvl   <= '0;
              r_shown <= w_req;
              r_state <= S_FADE_IN;
            end else begin
              r_lvl <= r_lvl - 1'b1;
            end
          end
        end
        S_FADE_IN: begin
          // A new request reverses direction from the current level.
          if (w_req != r_shown) begin
            r_state <= S_FADE_OUT;
          end else if (frame_start) begin
            if (r_lvl >= c_LMAX - 1'b1) begin
              r_lvl   <= c_LMAX;
              r_state <= S_IDLE;
            end else begin
              r_lvl <= r_lvl + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- Stage B: mode, fade, cursor ----------------
  function automatic logic [CW-1:0] f_scale(input logic [CW-1:0] c,
                                            input logic [FADE_BITS:0] l);
    logic [CW+FADE_BITS:0] p;
    p = c * l;
    return CW'(p >> FADE_BITS);
  endfunction

  logic [3*CW-1:0] w_mode_rgb;

  always_comb begin
    w_mode_rgb = OVER_RGB;
    case (r_shown)
      M_GAME:  w_mode_rgb = r_any ? r_col : BG_RGB;
      M_START: w_mode_rgb = START_RGB;
      default: w_mode_rgb = OVER_RGB;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else if (r_cur) begin
      {VGA_R, VGA_G, VGA_B} <= r_cur_col;
    end else begin
      VGA_R <= f_scale(w_mode_rgb[3*CW-1:2*CW], r_lvl);
      VGA_G <= f_scale(w_mode_rgb[2*CW-1:CW],   r_lvl);
      VGA_B <= f_scale(w_mode_rgb[CW-1:0],      r_lvl);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_compositor
//  Purpose  : Self-checking bench for layer_compositor. Directed scenarios
//             plus randomized traffic compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_layer_compositor;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, mouse_x = '0, mouse_y = '0;
  logic [23:0] layer_hit = '0, tex_rgb = '0, pal_data = '0;
  logic        start_signal = 1'b1, ingame_signal = 1'b0, gameover_signal = 1'b0;
  logic        leftButton = 1'b0, rightButton = 1'b0, pal_we = 1'b0;
  logic [4:0]  pal_addr = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        fading;

  layer_compositor dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .layer_hit(layer_hit), .tex_rgb(tex_rgb),
    .start_signal(start_signal), .ingame_signal(ingame_signal),
    .gameover_signal(gameover_signal), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .leftButton(leftButton), .rightButton(rightButton),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .fading(fading)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- Reference model ----------------
  // Modes: 0 game, 1 start, 2 over. Phases: 0 steady, 1 dimming, 2 brightening.
  localparam int LMAX = 16;
  logic [23:0] m_pal [24];
  int          m_phase, m_level, m_shown;
  logic [23:0] q [$];

  function automatic logic [23:0] fade24(input logic [23:0] c, input int lv);
    int r, g, b;
    r = (int'(c[23:16]) * lv) / LMAX;
    g = (int'(c[15:8])  * lv) / LMAX;
    b = (int'(c[7:0])   * lv) / LMAX;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  // Apply the current inputs for one clock, predict the pixel, then check
  // the output that is due two cycles after its inputs.
  task automatic step();
    int req, win, dx, dy;
    logic [23:0] col, mcol, e;
    bit cur;
    #1;
    if (Reset) begin
      for (int i = 0; i < 24; i++) m_pal[i] = 24'hFFFFFF;
      m_phase = 0; m_level = LMAX; m_shown = 1;
      q.delete();
      q.push_back(24'h000000);
      q.push_back(24'h6600FF);
    end else begin
      req = ingame_signal ? 0 : (start_signal ? 1 : 2);
      chk("fading", {31'd0, fading}, {31'd0, (m_phase != 0) || (req != m_shown)});
      win = -1;
      for (int i = 0; i < 24; i++) if (layer_hit[i] && win < 0) win = i;
      col = 24'h0;
      if (win >= 0) col = (win == 0 || win == 1) ? tex_rgb : m_pal[win];
      dx  = int'(DrawX) - int'(mouse_x);
      dy  = int'(DrawY) - int'(mouse_y);
      cur = (dx > -3) && (dx < 3) && (dy > -3) && (dy < 3);
      if (pal_we && pal_addr < 24) m_pal[pal_addr] = pal_data;
      case (m_phase)
        0: if (req != m_shown) m_phase = 1;
        1: if (frame_start) begin
             if (m_level > 0) m_level = m_level - 1;
             if (m_level == 0) begin m_shown = req; m_phase = 2; end
           end
        default: if (req != m_shown) m_phase = 1;
                 else if (frame_start) begin
                   m_level = m_level + 1;
                   if (m_level >= LMAX) begin m_level = LMAX; m_phase = 0; end
                 end
      endcase
      if (cur) e = leftButton ? 24'hFF0000 : (rightButton ? 24'h00FF00 : 24'hCCCCCC);
      else begin
        mcol = (m_shown == 0) ? ((win >= 0) ? col : 24'h808080) :
               (m_shown == 1) ? 24'h6600FF : 24'h000000;
        e = fade24(mcol, m_level);
      end
      q.push_back(e);
    end
    @(posedge Clk);
    @(negedge Clk);
    if (q.size() == 2) chk("vga", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, q.pop_front()});
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_start = 1'b1; step();
      frame_start = 1'b0; step();
    end
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    @(negedge Clk);
    // Reset with start screen requested, cursor far from the pixel.
    mouse_x = 10'd500; mouse_y = 10'd400; DrawX = 10'd100; DrawY = 10'd100;
    Reset = 1'b1; hold(3);
    Reset = 1'b0;
    chk("rst_vga", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0);
    #1 chk("rst_fading", {31'd0, fading}, 32'd0);
    hold(3);
    chk("start_screen", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h6600FF);

    // START -> GAME fade: midway at level 8, then complete.
    ingame_signal = 1'b1; step();
    frames(8); hold(3);
    chk("mid_fade_start", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h33007F);
    frames(8); frames(16); hold(3);
    chk("game_bg", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h808080);
    #1 chk("fade_done", {31'd0, fading}, 32'd0);

    // Palette write one cycle ahead; layers 3 and 9 hit, 3 wins.
    layer_hit = 24'h000208; pal_we = 1'b1; pal_addr = 5'd3; pal_data = 24'h0000FF; step();
    pal_we = 1'b0; step(); step();
    chk("pal_layer3", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0000FF);

    // Cursor at the screen corner with both buttons.
    mouse_x = 10'd1; mouse_y = 10'd1; DrawX = 10'd0; DrawY = 10'd0;
    leftButton = 1'b1; rightButton = 1'b1; hold(3);
    chk("cursor_corner", {8'd0, VGA_R, VGA_G, VGA_B}, 32'hFF0000);
    leftButton = 1'b0; rightButton = 1'b0;
    mouse_x = 10'd500; mouse_y = 10'd400; DrawX = 10'd100; DrawY = 10'd100;
    layer_hit = '0;

    // Reverse during fade-in, then reset mid-fade.
    ingame_signal = 1'b0; Reset = 1'b1; step(); Reset = 1'b0;
    ingame_signal = 1'b1; step();
    frames(16); frames(5);
    ingame_signal = 1'b0; hold(3);
    chk("reverse_l5", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h282828);
    frames(1); hold(2);
    chk("reverse_l4", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h202020);
    Reset = 1'b1; step(); Reset = 1'b0;
    chk("midfade_rst", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0);
    step();
    chk("post_rst_max", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h6600FF);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      Reset       = ($urandom_range(0, 599) == 0);
      frame_start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) begin
        ingame_signal   = $urandom_range(0, 1) == 1;
        start_signal    = $urandom_range(0, 1) == 1;
        gameover_signal = $urandom_range(0, 1) == 1;
      end
      case ($urandom_range(0, 3))
        0:       layer_hit = '0;
        1:       layer_hit = '1;
        2:       layer_hit = (24'd1 << $urandom_range(0, 23)) | (24'd1 << $urandom_range(0, 23));
        default: layer_hit = 24'($urandom & $urandom);
      endcase
      tex_rgb = 24'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        mouse_x = 10'($urandom_range(0, 6)); mouse_y = 10'($urandom_range(0, 6));
        DrawX   = 10'($urandom_range(0, 6)); DrawY   = 10'($urandom_range(0, 6));
      end else begin
        mouse_x = 10'($urandom); mouse_y = 10'($urandom);
        DrawX   = 10'($urandom); DrawY   = 10'($urandom);
      end
      leftButton  = $urandom_range(0, 1) == 1;
      rightButton = $urandom_range(0, 1) == 1;
      pal_we   = ($urandom_range(0, 3) == 0);
      pal_addr = 5'($urandom);
      pal_data = 24'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
